// File: rtl/execute_issue_scheduler_if.sv
// Decode->Execute issue bundle: decode request fields, writeback retire,
// LSU completion, and the scheduler's stall/issue/status outputs.
interface execute_issue_scheduler_if #(
    parameter int NUM_REGS = 32
);
    // Handshake: decode presents valid_decode with its fields; the transfer
    // happens in any cycle where issue=1 (valid_decode & ~stall). While stall=1
    // decode must hold every field stable; with valid_decode=0, stall is 0.
    logic                valid_decode;
    logic                au_decode;
    logic                mul_decode;
    logic                lsu_decode;
    logic                reg_write_decode;
    logic [4:0]          rd_decode;
    logic [4:0]          rs1_decode;
    logic [4:0]          rs2_decode;
    logic                rs1_used;
    logic                rs2_used;
    logic                lsu_done;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic                stall;
    logic                issue;
    logic                mul_busy;
    logic                lsu_busy;
    logic [NUM_REGS-1:0] pending;
    logic                lsu_state_dbg;

    modport master (
        output valid_decode, au_decode, mul_decode, lsu_decode, reg_write_decode,
        output rd_decode, rs1_decode, rs2_decode, rs1_used, rs2_used,
        output lsu_done, wb_valid, wb_rd,
        input  stall, issue, mul_busy, lsu_busy, pending, lsu_state_dbg
    );

    modport slave (
        input  valid_decode, au_decode, mul_decode, lsu_decode, reg_write_decode,
        input  rd_decode, rs1_decode, rs2_decode, rs1_used, rs2_used,
        input  lsu_done, wb_valid, wb_rd,
        output stall, issue, mul_busy, lsu_busy, pending, lsu_state_dbg
    );
endinterface

// File: rtl/execute_issue_scheduler.sv
// Decode->Execute issue controller: register scoreboard, multiplier occupancy
// and LSU busy tracking. Optional macro SB_WB_BYPASS_EN lets a retiring register resolve hazards same-cycle.
module execute_issue_scheduler #(
    parameter int MUL_LATENCY = 3,
    parameter int NUM_REGS    = 32
) (
    input logic clk,
    input logic rst_n,
    execute_issue_scheduler_if.slave bus
);
    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_t;

    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);
    localparam logic [3:0]          MUL_LOAD = 4'(MUL_LATENCY - 1);

    lsu_state_t          lsu_state;
    logic                lsu_busy_q;
    logic [3:0]          mul_cnt;
    logic                mul_busy;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] clear_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] hazard_view;
    logic                raw1;
    logic                raw2;
    logic                waw;
    logic                mulc;
    logic                lsuc;
    logic                stall;
    logic                issue;
    logic                unused_au;

    // The arithmetic unit is never a structural hazard.
    assign unused_au = bus.au_decode;

    always_comb begin
        clear_mask = '0;
        if (bus.wb_valid && bus.wb_rd != 5'd0) begin
            clear_mask = ONE_HOT0 << bus.wb_rd;
        end
    end

`ifdef SB_WB_BYPASS_EN
    assign hazard_view = pending_q & ~clear_mask;
`else
    assign hazard_view = pending_q;
`endif

    assign mul_busy = (mul_cnt != 4'd0);

    assign raw1  = bus.rs1_used && (bus.rs1_decode != 5'd0) && hazard_view[bus.rs1_decode];
    assign raw2  = bus.rs2_used && (bus.rs2_decode != 5'd0) && hazard_view[bus.rs2_decode];
    assign waw   = bus.reg_write_decode && (bus.rd_decode != 5'd0) && hazard_view[bus.rd_decode];
    assign mulc  = bus.mul_decode && mul_busy;
    assign lsuc  = bus.lsu_decode && lsu_busy_q;
    assign stall = bus.valid_decode && (raw1 || raw2 || waw || mulc || lsuc);
    assign issue = bus.valid_decode && !stall;

    always_comb begin
        set_mask = '0;
        if (issue && bus.reg_write_decode && bus.rd_decode != 5'd0) begin
            set_mask = ONE_HOT0 << bus.rd_decode;
        end
    end

    // Set is applied after clear so a same-index retire/issue leaves the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= ((pending_q & ~clear_mask) | set_mask) & ~ONE_HOT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= 4'd0;
        end else if (issue && bus.mul_decode) begin
            mul_cnt <= MUL_LOAD;
        end else if (mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
        end
    end

    // A request arriving with lsu_done while BUSY is stalled by lsuc above and
    // issues next cycle from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_state  <= LSU_IDLE;
            lsu_busy_q <= 1'b0;
        end else begin
            case (lsu_state)
                LSU_IDLE: begin
                    if (issue && bus.lsu_decode) begin
                        lsu_state  <= LSU_BUSY;
                        lsu_busy_q <= 1'b1;
                    end
                end
                LSU_BUSY: begin
                    if (bus.lsu_done) begin
                        lsu_state  <= LSU_IDLE;
                        lsu_busy_q <= 1'b0;
                    end
                end
                default: begin
                    lsu_state  <= LSU_IDLE;
                    lsu_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall         = stall;
    assign bus.issue         = issue;
    assign bus.mul_busy      = mul_busy;
    assign bus.lsu_busy      = lsu_busy_q;
    assign bus.pending       = pending_q;
    assign bus.lsu_state_dbg = lsu_state;
endmodule

// File: tb/tb_execute_issue_scheduler.sv
// Scoreboard bench for execute_issue_scheduler: directed hazard sequences then
// random traffic checked against a register/unit occupancy model.
module tb_execute_issue_scheduler;
    localparam int MUL_LATENCY = 3;
    localparam int NUM_REGS    = 32;
    localparam int EW          = NUM_REGS + 4;

    logic clk;
    logic rst_n;

    execute_issue_scheduler_if #(.NUM_REGS(NUM_REGS)) bus ();

    execute_issue_scheduler #(
        .MUL_LATENCY(MUL_LATENCY),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // reference model: set of outstanding registers, last MUL issue time, LSU busy flag
    bit pend_m[NUM_REGS];
    bit lsu_m;
    bit have_mul;
    int last_mul;
    int cyc;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pend_m[i] = 1'b0;
        lsu_m    = 1'b0;
        have_mul = 1'b0;
        last_mul = 0;
        cyc      = 0;
    endtask

    function automatic logic [NUM_REGS-1:0] pend_vec();
        logic [NUM_REGS-1:0] p;
        for (int i = 0; i < NUM_REGS; i++) p[i] = pend_m[i];
        return p;
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compare DUT outputs against the head of the expected queue
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("outputs{stall,issue,mul_busy,lsu_busy,pending}",
                  {bus.stall, bus.issue, bus.mul_busy, bus.lsu_busy, bus.pending}, e);
        end
    end

    task automatic set_idle_inputs();
        bus.valid_decode = 0; bus.au_decode = 0; bus.mul_decode = 0; bus.lsu_decode = 0;
        bus.reg_write_decode = 0; bus.rd_decode = 0; bus.rs1_decode = 0; bus.rs2_decode = 0;
        bus.rs1_used = 0; bus.rs2_used = 0; bus.lsu_done = 0; bus.wb_valid = 0; bus.wb_rd = 0;
    endtask

    // driver: apply one cycle of inputs, push expected, advance model at the edge
    task automatic drive(input bit v, input bit au, input bit mul, input bit lsu, input bit rw,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit done, input bit wbv,
                         input logic [4:0] wbrd);
        bit view[NUM_REGS];
        bit r1, r2, ww, mb, st, is;
        bus.valid_decode = v; bus.au_decode = au; bus.mul_decode = mul; bus.lsu_decode = lsu;
        bus.reg_write_decode = rw; bus.rd_decode = rd; bus.rs1_decode = rs1; bus.rs2_decode = rs2;
        bus.rs1_used = u1; bus.rs2_used = u2; bus.lsu_done = done; bus.wb_valid = wbv; bus.wb_rd = wbrd;
        for (int i = 0; i < NUM_REGS; i++) view[i] = pend_m[i];
`ifdef SB_WB_BYPASS_EN
        if (wbv && wbrd != 0) view[wbrd] = 1'b0;
`endif
        r1 = u1 && rs1 != 0 && view[rs1];
        r2 = u2 && rs2 != 0 && view[rs2];
        ww = rw && rd != 0 && view[rd];
        mb = have_mul && (cyc - last_mul) > 0 && (cyc - last_mul) < MUL_LATENCY;
        st = v && (r1 || r2 || ww || (mul && mb) || (lsu && lsu_m));
        is = v && !st;
        exp_q.push_back({st, is, mb, lsu_m, pend_vec()});
        @(posedge clk);
        if (wbv && wbrd != 0) pend_m[wbrd] = 1'b0;
        if (is && rw && rd != 0) pend_m[rd] = 1'b1;
        if (is && mul) begin
            have_mul = 1'b1;
            last_mul = cyc;
        end
        if (lsu_m) begin
            if (done) lsu_m = 1'b0;
        end else if (is && lsu) begin
            lsu_m = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle_inputs();
        model_reset();
        #7;
        check("reset_outputs", {bus.stall, bus.issue, bus.mul_busy, bus.lsu_busy, bus.pending}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW on x5: producer, dependent stalls until writeback
        drive(1, 1, 0, 0, 1, 5'd5, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0);
        repeat (3) drive(1, 1, 0, 0, 1, 5'd9, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0);
        drive(1, 1, 0, 0, 1, 5'd9, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5);
        drive(1, 1, 0, 0, 1, 5'd9, 5'd5, 5'd0, 1, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd9);
        idle_cycle();
        // WAW on x5
        drive(1, 1, 0, 0, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        repeat (2) drive(1, 1, 0, 0, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 1, 0, 0, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 1, 5'd5);
        drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd5);
        idle_cycle();
        // x0 never becomes pending; wb on a non-pending register is harmless
        drive(1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 1, 0, 0, 1, 5'd3, 5'd0, 5'd0, 1, 1, 0, 1, 5'd12);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd3);
        // MUL back-to-back with an AU op in between
        drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        repeat (3) drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        repeat (3) idle_cycle();
        // LSU: busy, stall, done together with request, then issue next cycle
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0);
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 5'd0);
        idle_cycle();
        // same-cycle retire and new write of x7
        drive(1, 1, 0, 0, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 1, 5'd7);
        idle_cycle();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd7);

        // reset mid-operation: LSU busy and x5 pending
        drive(1, 0, 0, 1, 1, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);
        set_idle_inputs();
        #1;
        check("pre_reset_state", {bus.stall, bus.issue, bus.mul_busy, bus.lsu_busy, bus.pending},
              {1'b0, 1'b0, 1'b0, lsu_m, pend_vec()});
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.stall, bus.issue, bus.mul_busy, bus.lsu_busy, bus.pending}, '0);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0);

        // random traffic on a small register window to keep hazards frequent
        repeat (600) begin
            int unit;
            unit = $urandom_range(0, 3);
            drive($urandom_range(0, 9) < 8, unit == 0, unit == 1, unit == 2, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
        end
        set_idle_inputs();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/execute_issue_scheduler.md
Name: execute_issue_scheduler

Overview:
- Issue controller for the Decode->Execute transfer register.
- Decides each cycle whether the instruction held in decode may pass to execute, or whether the transfer must hold (`stall`).
- Tracks the scoreboard of pending destination registers, the multi-cycle multiplier occupancy and the load/store unit busy state.
- Drives the `stall` input of the Decode->Execute register and the corresponding decode-stage hold.

Parameters:
- MUL_LATENCY, 3, cycles the multiplier stays occupied per MUL op; legal range 1..15; 1 = fully pipelined, back-to-back allowed.
- NUM_REGS, 32, architectural register count; scoreboard width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_decode  input  1  decode holds a valid instruction
- au_decode  input  1  instruction targets arithmetic unit
- mul_decode  input  1  instruction targets multiplier
- lsu_decode  input  1  instruction targets load/store unit
- reg_write_decode  input  1  instruction writes rd
- rd_decode  input  5  destination register
- rs1_decode  input  5  source 1 index
- rs2_decode  input  5  source 2 index
- rs1_used  input  1  source 1 is read
- rs2_used  input  1  source 2 is read
- lsu_done  input  1  LSU completion pulse
- wb_valid  input  1  writeback retiring a register write
- wb_rd  input  5  register being written back
- stall  output  1  hold Decode->Execute register and decode stage
- issue  output  1  instruction transfers to execute this cycle
- mul_busy  output  1  multiplier occupied
- lsu_busy  output  1  LSU FSM in BUSY
- pending  output  NUM_REGS  scoreboard, bit n = write to xn outstanding

Behaviour:
- Reset (async, rst_n=0):
  - pending=0, mul counter=0, LSU FSM=IDLE.
  - Hence stall=0, issue=0, mul_busy=0, lsu_busy=0.
  - Reset mid-operation discards all outstanding state immediately.
- Hazard terms (combinational, from registered state):
  - raw1 = rs1_used & rs1_decode!=0 & pending[rs1_decode]
  - raw2 = rs2_used & rs2_decode!=0 & pending[rs2_decode]
  - waw = reg_write_decode & rd_decode!=0 & pending[rd_decode]
  - mulc = mul_decode & mul_busy
  - lsuc = lsu_decode & lsu_busy
- Outputs:
  - stall = valid_decode & (raw1|raw2|waw|mulc|lsuc).
  - issue = valid_decode & ~stall.
  - stall=0 when valid_decode=0.
  - au_decode never causes a structural stall.
- Scoreboard update (next edge):
  - Issue with reg_write_decode & rd!=0 sets pending[rd].
  - wb_valid & wb_rd!=0 clears pending[wb_rd].
  - Set and clear of the same index in the same cycle: set wins.
  - pending[0] is constant 0.
  - wb_valid on a non-pending register has no effect.
- Multiplier counter (4 bits):
  - MUL issue loads MUL_LATENCY-1; otherwise decrement while nonzero.
  - mul_busy = counter!=0.
  - Next MUL can issue MUL_LATENCY cycles after the previous one.
- LSU FSM:
  - IDLE -> BUSY on LSU issue.
  - BUSY -> IDLE on lsu_done.
  - lsu_done in IDLE is ignored.
  - lsu_done and a new LSU request in the same BUSY cycle: request stalls that cycle and issues the next cycle.
- Latency: issue/stall are combinational in the same cycle as the inputs; state updates take effect at the next edge.
- Priority: reset > state updates. No other ordering dependencies.

Optional Feature:
- Macro: SB_WB_BYPASS_EN
- Defined: raw1/raw2/waw use (pending & ~clear_mask), where clear_mask is the one-hot of wb_rd when wb_valid & wb_rd!=0. A source retiring this cycle does not stall.
- Undefined: hazard terms use registered pending only. A dependent instruction stalls one extra cycle after its producer's writeback.

Test Plan:
- Reset: rst_n low mid-LSU-BUSY with pending=0x0000_0020 -> all outputs 0 immediately; after release, valid LSU op issues with no stall.
- RAW/WAW:
  - Issue write to x5, then valid op with rs1=5 -> stall=1 until wb_valid with wb_rd=5.
  - Without SB_WB_BYPASS_EN, issue occurs the cycle after writeback; with it, in the writeback cycle.
  - rd=x5 while pending[5]=1 also stalls.
- x0: write to x0 followed by op reading x0 -> pending stays 0, no stall.
- MUL structural (MUL_LATENCY=3): two back-to-back MUL ops -> second stalls 2 cycles and issues on the 3rd cycle. An AU op in between issues without stall.
- LSU:
  - LSU op issues -> lsu_busy=1; second LSU op stalls.
  - lsu_done in the same cycle as that request -> issue the following cycle.
  - lsu_done while IDLE -> no state change.
- Same-cycle set/clear: wb_rd=7 retires while a new write to x7 issues -> pending[7]=1 afterwards.
